ptp_tx_gen: RTL

Layer-2 PTP event frame generator: the transmit-side counterpart of the TSU's PTP parser. On a request it builds a complete 60-byte Ethernet/PTPv2 frame and streams it onto the 32-bit packet interface with sop/eop/mod framing and ready backpressure. Its output is byte-compatible with what the receive-side parser extracts: ethertype 0x88F7, messageType at word 3 [11:8], and sequenceId at word 11 [31:16]. It sits between the PTP protocol engine and the MAC transmit path, upstream of the TX TSU.

---
 rtl/ptp_tx_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ptp_tx_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : ptp_tx_gen                                                       |
// | Purpose  : Builds a 60-byte Layer-2 PTPv2 event frame on request and streams |
// |            it as 15 big-endian 32-bit words with sop/eop/ready handshake.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module ptp_tx_gen #(
  parameter logic [47:0] DST_MAC  = 48'h011B19000000,
  parameter logic [47:0] SRC_MAC  = 48'h000000000000,
  parameter logic [63:0] CLOCK_ID = 64'h0,
  parameter logic [15:0] PORT_NUM = 16'd1,
  parameter logic [7:0]  DOMAIN   = 8'd0,
  parameter logic [7:0]  LOG_SYNC = 8'h00
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        tx_req,
  input  wire logic [3:0]  tx_msgid,
  input  wire logic [15:0] tx_seqid,
  input  wire logic [47:0] tx_ts_sec,
  input  wire logic [31:0] tx_ts_ns,
  output logic             tx_ack,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [31:0]      tx_data,
  output logic             tx_valid,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic [1:0]       tx_mod,
  input  wire logic        tx_ready
);

  localparam logic [3:0]  c_last_word = 4'd14;
  localparam logic [15:0] c_ethertype = 16'h88F7;
  localparam logic [15:0] c_msg_len   = 16'd44;
  localparam logic [7:0]  c_ptp_ver   = 8'h02;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [31:0] r_data, w_data_d;
  logic        r_valid, w_valid_d;
  logic        r_sop, w_sop_d;
  logic        r_eop, w_eop_d;
  logic        r_ack, w_ack_d;
  logic        r_busy, w_busy_d;
  logic        r_done, w_done_d;
  logic [3:0]  r_msgid, w_msgid_d;
  logic [15:0] r_seqid, w_seqid_d;
  logic [47:0] r_sec, w_sec_d;
  logic [31:0] r_ns, w_ns_d;
  logic        w_accept;
  logic [3:0]  w_cnt_next;

  // Frame word lookup from the latched per-frame fields and the fixed parameters.
  function automatic logic [31:0] frame_word(
    input logic [3:0]  idx,
    input logic [3:0]  msgid,
    input logic [15:0] seqid,
    input logic [47:0] sec,
    input logic [31:0] ns
  );
    logic [7:0]  ctrl;
    logic [7:0]  log_int;
    logic [31:0] word;
    ctrl    = (msgid == 4'd0) ? 8'h00 : ((msgid == 4'd1) ? 8'h01 : 8'h05);
    log_int = (msgid == 4'd0) ? LOG_SYNC : 8'h7F;
    case (idx)
      4'd0:    word = DST_MAC[47:16];
      4'd1:    word = {DST_MAC[15:0], SRC_MAC[47:32]};
      4'd2:    word = SRC_MAC[31:0];
      4'd3:    word = {c_ethertype, 4'h0, msgid, c_ptp_ver};
      4'd4:    word = {c_msg_len, DOMAIN, 8'h00};
      4'd8:    word = {16'h0000, CLOCK_ID[63:48]};
      4'd9:    word = CLOCK_ID[47:16];
      4'd10:   word = {CLOCK_ID[15:0], PORT_NUM};
      4'd11:   word = {seqid, ctrl, log_int};
      4'd12:   word = sec[47:16];
      4'd13:   word = {sec[15:0], ns[31:16]};
      4'd14:   word = {ns[15:0], 16'h0000};
      default: word = 32'h0;
    endcase
    return word;
  endfunction

  assign w_accept   = r_valid && tx_ready;
  assign w_cnt_next = r_cnt + 4'd1;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_data_d  = r_data;
    w_valid_d = r_valid;
    w_sop_d   = r_sop;
    w_eop_d   = r_eop;
    w_ack_d   = 1'b0;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_msgid_d = r_msgid;
    w_seqid_d = r_seqid;
    w_sec_d   = r_sec;
    w_ns_d    = r_ns;
    case (r_state)
      ST_IDLE: begin
        if (tx_req) begin
          w_state_d = ST_SEND;
          w_msgid_d = tx_msgid;
          w_seqid_d = tx_seqid;
          w_sec_d   = tx_ts_sec;
          w_ns_d    = tx_ts_ns;
          w_cnt_d   = 4'd0;
          w_data_d  = frame_word(4'd0, tx_msgid, tx_seqid, tx_ts_sec, tx_ts_ns);
          w_valid_d = 1'b1;
          w_sop_d   = 1'b1;
          w_eop_d   = 1'b0;
          w_ack_d   = 1'b1;
          w_busy_d  = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_accept) begin
          if (r_cnt == c_last_word) begin
            // Counter stays at the last index until the next frame reloads it.
            w_state_d = ST_IDLE;
            w_valid_d = 1'b0;
            w_sop_d   = 1'b0;
            w_eop_d   = 1'b0;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
            w_data_d  = 32'h0;
          end else begin
            w_cnt_d   = w_cnt_next;
            w_data_d  = frame_word(w_cnt_next, r_msgid, r_seqid, r_sec, r_ns);
            w_sop_d   = 1'b0;
            w_eop_d   = (w_cnt_next == c_last_word);
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_data  <= 32'h0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_msgid <= 4'd0;
      r_seqid <= 16'd0;
      r_sec   <= 48'd0;
      r_ns    <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_data  <= w_data_d;
      r_valid <= w_valid_d;
      r_sop   <= w_sop_d;
      r_eop   <= w_eop_d;
      r_ack   <= w_ack_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_msgid <= w_msgid_d;
      r_seqid <= w_seqid_d;
      r_sec   <= w_sec_d;
      r_ns    <= w_ns_d;
    end
  end

  assign tx_ack   = r_ack;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;
  assign tx_data  = r_data;
  assign tx_valid = r_valid;
  assign tx_sop   = r_sop;
  assign tx_eop   = r_eop;
  assign tx_mod   = 2'b00;

endmodule
`default_nettype wire
